// File: rtl/fsqrt_sched.sv
// Round-robin scheduler sharing one pipelined fsqrt unit among NREQ requesters.
// Credit-gated issue, tag pipe, response FIFO; FSQRT_SCHED_STATS_EN adds stat_issue/stat_stall.
module fsqrt_sched #(
  parameter int NREQ   = 2,
  parameter int NSTAGE = 4,
  parameter int FDEPTH = 8,
  parameter int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*32-1:0] req_x,
  output logic [NREQ-1:0]   req_ready,
  output logic [31:0]       sq_x,
  output logic              sq_en,
  input  logic [31:0]       sq_y,
  input  logic              sq_exc,
  input  logic              sq_en_out,
  output logic              resp_valid,
  output logic [IDW-1:0]    resp_id,
  output logic [31:0]       resp_y,
  output logic              resp_exc,
  input  logic              resp_ready,
  output logic              err
`ifdef FSQRT_SCHED_STATS_EN
  ,
  output logic [31:0]       stat_issue,
  output logic [31:0]       stat_stall
`endif
);

  localparam int PW = $clog2(FDEPTH);
  localparam int CW = PW + 1;
  localparam int EW = IDW + 33;

  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic              eligible, xfer;
  logic [NREQ-1:0]   grant_oh;
  logic [IDW-1:0]    grant_id;
  logic [31:0]       grant_x;
  int                arb_idx;

  logic              sq_en_q, sq_en_d;
  logic [31:0]       sq_x_q, sq_x_d;
  logic [IDW-1:0]    iss_id_q, iss_id_d;
  logic [NSTAGE-1:0] tag_v_q, tag_v_d;
  logic [IDW-1:0]    tag_id_q [NSTAGE];
  logic [IDW-1:0]    tag_id_d [NSTAGE];

  logic [EW-1:0]     mem [FDEPTH];
  logic [EW-1:0]     head;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop, full, wr_en;
  logic              err_q, err_d;

  // inflight covers the issue register, the tag pipe and the FIFO
  assign eligible = inflight_q < CW'(FDEPTH);

  always_comb begin
    grant_oh = '0;
    grant_id = '0;
    grant_x  = '0;
    arb_idx  = 0;
    for (int k = 0; k < NREQ; k++) begin
      arb_idx = (int'(ptr_q) + k) % NREQ;
      if (eligible && (grant_oh == '0) && req_valid[arb_idx]) begin
        grant_oh[arb_idx] = 1'b1;
        grant_id          = IDW'(arb_idx);
        grant_x           = req_x[32*arb_idx +: 32];
      end
    end
  end

  assign xfer      = |grant_oh;
  assign req_ready = grant_oh;

  always_comb begin
    ptr_d    = ptr_q;
    sq_en_d  = xfer;
    sq_x_d   = sq_x_q;
    iss_id_d = iss_id_q;
    if (xfer) begin
      ptr_d    = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
      sq_x_d   = grant_x;
      iss_id_d = grant_id;
    end
    tag_v_d[0]  = sq_en_q;
    tag_id_d[0] = iss_id_q;
    for (int k = 1; k < NSTAGE; k++) begin
      tag_v_d[k]  = tag_v_q[k-1];
      tag_id_d[k] = tag_id_q[k-1];
    end
  end

  // A valid last tag always pushes; a stray sq_en_out without a tag is ignored
  always_comb begin
    push       = tag_v_q[NSTAGE-1];
    pop        = (count_q != '0) && resp_ready;
    full       = (count_q == CW'(FDEPTH));
    wr_en      = push && (!full || pop);
    wr_ptr_d   = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(wr_en) - CW'(pop);
    inflight_d = inflight_q + CW'(xfer) - CW'(pop);
    err_d      = err_q | (push & ~sq_en_out) | (push & full & ~pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      inflight_q <= '0;
      sq_en_q    <= 1'b0;
      sq_x_q     <= '0;
      iss_id_q   <= '0;
      tag_v_q    <= '0;
      for (int k = 0; k < NSTAGE; k++) tag_id_q[k] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      sq_en_q    <= sq_en_d;
      sq_x_q     <= sq_x_d;
      iss_id_q   <= iss_id_d;
      tag_v_q    <= tag_v_d;
      for (int k = 0; k < NSTAGE; k++) tag_id_q[k] <= tag_id_d[k];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= {tag_id_q[NSTAGE-1], sq_y, sq_exc};
  end

  assign head       = mem[rd_ptr_q];
  assign resp_valid = (count_q != '0);
  assign resp_id    = resp_valid ? head[EW-1 -: IDW] : '0;
  assign resp_y     = resp_valid ? head[32:1] : '0;
  assign resp_exc   = resp_valid ? head[0] : 1'b0;
  assign sq_en      = sq_en_q;
  assign sq_x       = sq_x_q;
  assign err        = err_q;

`ifdef FSQRT_SCHED_STATS_EN
  logic [31:0] stat_issue_q, stat_issue_d, stat_stall_q, stat_stall_d;

  always_comb begin
    stat_issue_d = stat_issue_q + 32'(xfer);
    stat_stall_d = stat_stall_q + 32'((|req_valid) && !eligible);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issue_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_issue_q <= stat_issue_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_issue = stat_issue_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_fsqrt_sched.sv
// Scoreboard bench for fsqrt_sched: randomized and directed traffic against a
// queue-based model of round-robin grant, credit limit and in-order responses.
module tb_fsqrt_sched;
  localparam int NREQ   = 2;
  localparam int NSTAGE = 4;
  localparam int FDEPTH = 8;
  localparam int IDW    = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*32-1:0] req_x;
  logic [NREQ-1:0]   req_ready;
  logic [31:0]       sq_x, sq_y;
  logic              sq_en, sq_exc, sq_en_out;
  logic              resp_valid, resp_exc, resp_ready, err;
  logic [IDW-1:0]    resp_id;
  logic [31:0]       resp_y;
`ifdef FSQRT_SCHED_STATS_EN
  logic [31:0]       stat_issue, stat_stall;
`endif

  fsqrt_sched #(.NREQ(NREQ), .NSTAGE(NSTAGE), .FDEPTH(FDEPTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .sq_x(sq_x), .sq_en(sq_en), .sq_y(sq_y), .sq_exc(sq_exc), .sq_en_out(sq_en_out),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_y(resp_y), .resp_exc(resp_exc),
    .resp_ready(resp_ready), .err(err)
`ifdef FSQRT_SCHED_STATS_EN
    , .stat_issue(stat_issue), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in fsqrt unit: known square roots for the directed values, a fixed
  // scramble otherwise; exception for negative non-zero operands.
  function automatic logic [31:0] ref_y(input logic [31:0] x);
    case (x)
      32'h40800000: return 32'h40000000;
      32'h3F800000: return 32'h3F800000;
      32'hBF800000: return 32'h7FC00000;
      default:      return {1'b0, x[31:1]} ^ 32'h0A5A_5A5A;
    endcase
  endfunction

  function automatic logic ref_exc(input logic [31:0] x);
    return x[31] && (x[30:0] != 31'd0);
  endfunction

  logic              kill = 1'b0;
  logic [NSTAGE-1:0] en_p = '0;
  logic [31:0]       x_p [NSTAGE];

  always @(posedge clk) begin
    en_p    <= {en_p[NSTAGE-2:0], sq_en};
    x_p[0]  <= sq_x;
    for (int k = 1; k < NSTAGE; k++) x_p[k] <= x_p[k-1];
  end

  assign sq_en_out = en_p[NSTAGE-1] & ~kill;
  assign sq_y      = ref_y(x_p[NSTAGE-1]);
  assign sq_exc    = ref_exc(x_p[NSTAGE-1]);

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    y;
    logic           exc;
    int             due;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;
  int          m_ptr, m_issue, m_stall, obs_xfer;
  logic        m_sqen, m_err, err_dc, mon_en;
  logic [31:0] m_sqx;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: head of the expected queue becomes visible once its due cycle is reached
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_valid;
      exp_valid = (q.size() > 0) && (cyc >= q[0].due);
      chk("resp_valid", resp_valid, exp_valid);
      if (resp_valid && exp_valid) begin
        $display("resp id=%0d y=%08h exc=%0d", resp_id, resp_y, resp_exc);
        chk("resp_id", resp_id, q[0].id);
        chk("resp_y", resp_y, q[0].y);
        chk("resp_exc", resp_exc, q[0].exc);
        if (resp_ready) void'(q.pop_front());
      end
      if (!err_dc) chk("err", err, m_err);
    end
  end

  task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ*32-1:0] xs, input logic rr);
    logic [NREQ-1:0] exp_rdy;
    logic            elig;
    int              g;
    @(posedge clk);
    #1;
    req_valid  = v;
    req_x      = xs;
    resp_ready = rr;
    #1;
    elig    = (q.size() < FDEPTH);
    exp_rdy = '0;
    g       = -1;
    if (elig) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    @(negedge clk);
    chk("req_ready", req_ready, exp_rdy);
    chk("sq_en", sq_en, m_sqen);
    chk("sq_x", sq_x, m_sqx);
`ifdef FSQRT_SCHED_STATS_EN
    chk("stat_issue", stat_issue, m_issue);
    chk("stat_stall", stat_stall, m_stall);
`endif
    obs_xfer += $countones(req_ready & v);
    if (|v && !elig) m_stall++;
    m_sqen = (g >= 0);
    if (g >= 0) begin
      logic [31:0] x;
      x     = xs[32*g +: 32];
      m_sqx = x;
      q.push_back('{id: IDW'(g), y: ref_y(x), exc: ref_exc(x), due: cyc + NSTAGE + 2});
      $display("issue req=%0d x=%08h cycle=%0d", g, x, cyc);
      m_ptr = (g + 1) % NREQ;
      m_issue++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    q.delete();
    m_ptr   = 0;
    m_sqen  = 1'b0;
    m_sqx   = '0;
    m_issue = 0;
    m_stall = 0;
    m_err   = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_sq_en", sq_en, 0);
    chk("rst_sq_x", sq_x, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_y", resp_y, 0);
    chk("rst_resp_exc", resp_exc, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && q.size() > 0; t++) drive('0, '0, 1'b1);
    drive('0, '0, 1'b1);
    chk("drain_empty", q.size(), 0);
  endtask

  function automatic logic [31:0] rand_x();
    case ($urandom_range(0, 5))
      0:       return 32'h40800000;
      1:       return 32'hBF800000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b0; req_valid = '0; req_x = '0; resp_ready = 1'b0;
    err_dc = 1'b0; m_err = 1'b0; mon_en = 1'b0;
    m_ptr = 0; m_issue = 0; m_stall = 0; m_sqen = 1'b0; m_sqx = '0; obs_xfer = 0;
    #1 rst = 1'b1;
    do_reset();
    mon_en = 1'b1;

    // single operands from each requester, in order
    drive(2'b01, {32'h0, 32'h40800000}, 1'b1);
    repeat (8) drive('0, '0, 1'b1);
    drive(2'b10, {32'hBF800000, 32'h0}, 1'b1);
    drive(2'b10, {32'h3F800000, 32'h0}, 1'b1);
    repeat (8) drive('0, '0, 1'b1);

    // back-to-back alternating grants
    repeat (8) drive(2'b11, {rand_x(), rand_x()}, 1'b1);
    drain();

    // credit limit: exactly FDEPTH transfers, then one per pop
    obs_xfer = 0;
    repeat (20) drive(2'b11, {rand_x(), rand_x()}, 1'b0);
    chk("fill_xfers", obs_xfer, FDEPTH);
    obs_xfer = 0;
    drive(2'b11, {rand_x(), rand_x()}, 1'b1);
    repeat (5) drive(2'b11, {rand_x(), rand_x()}, 1'b0);
    chk("refill_xfers", obs_xfer, 1);
    drain();

    // randomized traffic with backpressure
    repeat (400) drive(NREQ'($urandom), {rand_x(), rand_x()}, ($urandom_range(0, 3) != 0));
    drain();

    // reset with operands in flight: nothing must emerge afterwards
    drive(2'b01, {rand_x(), rand_x()}, 1'b1);
    drive(2'b10, {rand_x(), rand_x()}, 1'b1);
    drive(2'b01, {rand_x(), rand_x()}, 1'b1);
    do_reset();
    repeat (12) drive('0, '0, 1'b1);

    // missing enable_out when a tag completes: sticky err, result still delivered
    err_dc = 1'b1;
    kill   = 1'b1;
    drive(2'b01, {32'h0, 32'h40800000}, 1'b1);
    repeat (NSTAGE + 4) drive('0, '0, 1'b1);
    kill   = 1'b0;
    m_err  = 1'b1;
    err_dc = 1'b0;
    repeat (4) drive('0, '0, 1'b1);
    chk("queue_after_err", q.size(), 0);
    do_reset();
    repeat (2) drive('0, '0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fsqrt_sched.md
Name: fsqrt_sched

Overview:
- Shares one fully pipelined fsqrt unit among NREQ requesters.
- Round-robin arbitration; issues at most one operand per cycle.
- Tracks requester IDs alongside the fsqrt pipeline and buffers results in a response FIFO.
- Credit-based issue guarantees the non-stallable fsqrt pipeline never overflows the FIFO.

Parameters:
- NREQ, 2, number of requesters (2..8).
- NSTAGE, 4, fsqrt latency in cycles, from enable_in to enable_out.
- FDEPTH, 8, response FIFO depth. Must be at least NSTAGE+2 for full throughput; power of two.
- IDW, $clog2(NREQ) (min 1), requester-ID width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_x  in  NREQ*32  operands; requester i uses bits [32*i+31:32*i].
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- sq_x  out  32  operand to fsqrt x1.
- sq_en  out  1  to fsqrt enable_in.
- sq_y  in  32  fsqrt result y.
- sq_exc  in  1  fsqrt exception.
- sq_en_out  in  1  fsqrt enable_out.
- resp_valid  out  1  response FIFO non-empty.
- resp_id  out  IDW  requester of head result.
- resp_y  out  32  head result.
- resp_exc  out  1  head exception.
- resp_ready  in  1  consumer pops head.
- err  out  1  sticky protocol error.

Behaviour:
- Reset values: req_ready=0, sq_en=0, sq_x=0, resp_valid=0, resp_id=0, resp_y=0, resp_exc=0, err=0. Reset also clears the RR pointer (0), tag pipe, FIFO and credit counter.
- Credit: inflight counts entries in the tag pipe plus entries in the FIFO. eligible = (inflight < FDEPTH).
  - Issue only: +1. Pop only: -1. Issue and pop in the same cycle: unchanged.
- Arbitration (combinational):
  - If eligible, grant the first i with req_valid[i]=1, scanning from ptr upward and wrapping modulo NREQ.
  - req_ready = one-hot of the grant; all zero if not eligible or no valid.
  - Transfer when req_valid[i] & req_ready[i].
  - On transfer, ptr <= grant+1 mod NREQ. Otherwise ptr holds.
- Issue register: at the transfer edge E, sq_x <= selected operand and sq_en <= 1. On edges with no transfer, sq_en <= 0 and sq_x holds.
- Tag pipe: NSTAGE-deep shift of {v, id}, aligned with sq_en so that its last stage matches sq_en_out.
- Completion, with last tag stage t:
  - t.v=1 and sq_en_out=1: push {t.id, sq_y, sq_exc} into the FIFO.
  - t.v=1 and sq_en_out=0: set err and push anyway.
  - t.v=0 and sq_en_out=1 (stale result after reset): discard silently.
- Latency: operand accepted at edge E → resp_valid first high in the cycle after edge E+NSTAGE+1, when the FIFO is empty.
- FIFO:
  - No fall-through; resp_* show the head entry registered.
  - Pop on resp_valid & resp_ready.
  - Push and pop in the same cycle is allowed, including when full.
  - Pointers wrap modulo FDEPTH.
  - A push while full (impossible under credit) sets err and drops the entry.
- Ordering: responses leave in issue order, across all requesters.
- Reset mid-operation: in-flight and buffered results are lost. Late sq_en_out pulses are discarded per the completion rules.

Optional Feature:
- FSQRT_SCHED_STATS_EN defined:
  - Adds outputs stat_issue (32, total transfers) and stat_stall (32, cycles with any req_valid but no transfer because not eligible).
  - Both counters wrap modulo 2^32 and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Requester 0 sends 0x40800000 (4.0), resp_ready=1 → after NSTAGE+2 edges: resp_id=0, resp_y=0x40000000, resp_exc=0. Then resp_valid=0.
- Requester 1 sends 0xBF800000 → resp_id=1, resp_exc=1. A following 0x3F800000 returns 0x3F800000, exc=0, in order.
- Both requesters valid continuously for 8 cycles → grants alternate 0,1,0,1,…. sq_en stays high every cycle. Responses arrive with resp_id alternating.
- resp_ready=0, both valid → exactly FDEPTH=8 transfers, then req_ready=0 persistently. Pop one → exactly one more transfer. err stays 0.
- Issue 3 operands, assert rst for 1 cycle mid-flight → all outputs at reset values. No response ever appears. err=0.
- Force sq_en_out=0 when a tag reaches the last stage → err=1 and remains 1 until rst. With FSQRT_SCHED_STATS_EN, stat_issue equals the transfer count and stat_stall counts the full-FIFO cycles.
